// File: rtl/adc_spi_responder.sv
// Responder end of the serial ADC link: shifts a zero-led DATA_W-bit sample out on s_data, MSB first.
// Optional feature: define RAMP_GEN_EN to transmit an internal ramp in place of sample_data.
module adc_spi_responder #(
  parameter int unsigned DATA_W     = 12,
  parameter int unsigned LEAD_ZEROS = 4
`ifdef RAMP_GEN_EN
  ,
  parameter int unsigned RAMP_STEP  = 1
`endif
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cs,
  input  logic              s_clk,
  input  logic [DATA_W-1:0] sample_data,
  output logic              s_data,
  output logic              busy,
  output logic              frame_done,
  output logic              frame_abort
);

  localparam int unsigned FRAME = LEAD_ZEROS + DATA_W;
  localparam int unsigned CNT_W = 5;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    SHIFT   = 2'd1,
    WAIT_CS = 2'd2
  } state_t;

  state_t             state, state_nxt;
  logic [FRAME-1:0]   shreg, shreg_nxt;
  logic [CNT_W-1:0]   bit_cnt, bit_cnt_nxt;
  logic               s_data_nxt;
  logic               busy_nxt;
  logic               frame_done_nxt;
  logic               frame_abort_nxt;

  // [0],[1] synchronise; [2] is the previous synchronised value for edge detect
  logic [2:0]         cs_pipe;
  logic [2:0]         sclk_pipe;
  logic [1:0]         settle;
  logic               armed;

  logic               cs_fall;
  logic               cs_rise;
  logic               sclk_fall;
  logic [DATA_W-1:0]  capture_val;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cs_pipe   <= 3'b111;
      sclk_pipe <= 3'b111;
      settle    <= 2'b00;
      armed     <= 1'b0;
    end else begin
      cs_pipe   <= {cs_pipe[1:0], cs};
      sclk_pipe <= {sclk_pipe[1:0], s_clk};
      settle    <= {settle[0], 1'b1};
      // cs must be seen high from the pin (not the reset value) before a fall counts
      armed     <= armed | (settle[1] & cs_pipe[1]);
    end
  end

  assign cs_fall   = armed & cs_pipe[2] & ~cs_pipe[1];
  assign cs_rise   = ~cs_pipe[2] & cs_pipe[1];
  assign sclk_fall = sclk_pipe[2] & ~sclk_pipe[1];

`ifdef RAMP_GEN_EN
  logic [DATA_W-1:0] ramp, ramp_nxt;
  logic              unused_sample;

  assign unused_sample = ^sample_data;
  assign capture_val   = ramp;

  // Ramp advances only on completed frames
  always_comb begin
    ramp_nxt = ramp;
    if (frame_done_nxt) begin
      ramp_nxt = ramp + DATA_W'(RAMP_STEP);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ramp <= '0;
    end else begin
      ramp <= ramp_nxt;
    end
  end
`else
  assign capture_val = sample_data;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      shreg       <= '0;
      bit_cnt     <= '0;
      s_data      <= 1'b0;
      busy        <= 1'b0;
      frame_done  <= 1'b0;
      frame_abort <= 1'b0;
    end else begin
      state       <= state_nxt;
      shreg       <= shreg_nxt;
      bit_cnt     <= bit_cnt_nxt;
      s_data      <= s_data_nxt;
      busy        <= busy_nxt;
      frame_done  <= frame_done_nxt;
      frame_abort <= frame_abort_nxt;
    end
  end

  always_comb begin
    state_nxt       = state;
    shreg_nxt       = shreg;
    bit_cnt_nxt     = bit_cnt;
    s_data_nxt      = s_data;
    frame_done_nxt  = 1'b0;
    frame_abort_nxt = 1'b0;

    case (state)
      IDLE: begin
        s_data_nxt = 1'b0;
        if (cs_fall) begin
          shreg_nxt   = {{LEAD_ZEROS{1'b0}}, capture_val};
          s_data_nxt  = shreg_nxt[FRAME-1];
          bit_cnt_nxt = CNT_W'(FRAME - 1);
          state_nxt   = SHIFT;
        end
      end

      SHIFT: begin
        // Last falling edge beats a coincident cs rise: done, then straight to IDLE
        if (sclk_fall && (bit_cnt == '0)) begin
          frame_done_nxt = 1'b1;
          s_data_nxt     = 1'b0;
          state_nxt      = cs_rise ? IDLE : WAIT_CS;
        end else if (cs_rise) begin
          frame_abort_nxt = 1'b1;
          s_data_nxt      = 1'b0;
          bit_cnt_nxt     = '0;
          state_nxt       = IDLE;
        end else if (sclk_fall) begin
          shreg_nxt   = {shreg[FRAME-2:0], 1'b0};
          s_data_nxt  = shreg[FRAME-2];
          bit_cnt_nxt = bit_cnt - CNT_W'(1);
        end
      end

      WAIT_CS: begin
        s_data_nxt = 1'b0;
        if (cs_rise) begin
          state_nxt = IDLE;
        end
      end

      default: begin
        s_data_nxt = 1'b0;
        state_nxt  = IDLE;
      end
    endcase

    busy_nxt = (state_nxt != IDLE);
  end

endmodule

// File: tb/tb_adc_spi_responder.sv
// Directed bench for adc_spi_responder: table of frames plus reset, overrun and coincident-edge sequences.
`timescale 1ns/100ps
module tb_adc_spi_responder;

  localparam int HALF = 40; // clk cycles per s_clk half period (8 MHz / 80 = 100 kHz)

  logic        clk;
  logic        rst_n;
  logic        cs;
  logic        s_clk;
  logic [11:0] sample_data;
  logic        s_data;
  logic        busy;
  logic        frame_done;
  logic        frame_abort;

  adc_spi_responder dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .cs          (cs),
    .s_clk       (s_clk),
    .sample_data (sample_data),
    .s_data      (s_data),
    .busy        (busy),
    .frame_done  (frame_done),
    .frame_abort (frame_abort)
  );

  initial clk = 1'b0;
  always #62.5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  // Pulse monitor: rising occurrences and total high cycles
  int   done_cnt = 0, done_hi = 0, abort_cnt = 0, abort_hi = 0;
  logic done_q = 1'b0, abort_q = 1'b0;
  always @(negedge clk) begin
    if (frame_done) done_hi <= done_hi + 1;
    if (frame_done && !done_q) done_cnt <= done_cnt + 1;
    if (frame_abort) abort_hi <= abort_hi + 1;
    if (frame_abort && !abort_q) abort_cnt <= abort_cnt + 1;
    done_q  <= frame_done;
    abort_q <= frame_abort;
  end

  logic [11:0] ramp_model = 12'h000;

  typedef struct {
    logic [11:0] sample;
    int          falls;
    logic [15:0] exp_rx;
    int          exp_done;
    int          exp_abort;
  } vec_t;

  vec_t vecs[6];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    else n_pass++;
  endtask

  task automatic wait_clks(input int n);
    repeat (n) @(negedge clk);
  endtask

  function automatic logic [15:0] exp_word(input logic [11:0] sample, input int falls);
    logic [15:0] w;
`ifdef RAMP_GEN_EN
    w = {4'h0, ramp_model};
`else
    w = {4'h0, sample};
`endif
    return w >> (16 - falls);
  endfunction

  // Drops cs, then samples s_data just before each falling edge; leaves cs low
  task automatic run_frame(input logic [11:0] sample, input int falls, output logic [15:0] rx);
    sample_data = sample;
    rx = 16'h0;
    cs = 1'b0;
    wait_clks(2);
    check("busy_before_latency", 32'(busy), 32'd0);
    wait_clks(1);
    check("busy_after_latency", 32'(busy), 32'd1);
    sample_data = ~sample;
    wait_clks(HALF - 3);
    for (int i = 0; i < falls; i++) begin
      rx = {rx[14:0], s_data};
      s_clk = 1'b0;
      wait_clks(HALF);
      s_clk = 1'b1;
      wait_clks(HALF);
    end
  endtask

  initial begin
    #20ms;
    $display("FAIL watchdog: got timeout, expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [15:0] rx;
    logic        sd_seen, busy_seen;
    int d0, h0, a0, ah0;

    vecs[0] = '{12'hA5C, 16, 16'h0A5C, 1, 0};
    vecs[1] = '{12'hFFF, 16, 16'h0FFF, 1, 0};
    vecs[2] = '{12'h000, 16, 16'h0000, 1, 0};
    vecs[3] = '{12'h5A3,  7, 16'h0002, 0, 1};
    vecs[4] = '{12'h123, 16, 16'h0123, 1, 0};
    vecs[5] = '{12'h800, 16, 16'h0800, 1, 0};

    rst_n = 1'b0; cs = 1'b1; s_clk = 1'b1; sample_data = 12'h000;
    wait_clks(4);
    check("rst_s_data", 32'(s_data), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(frame_done), 32'd0);
    check("rst_abort", 32'(frame_abort), 32'd0);
    rst_n = 1'b1;
    wait_clks(HALF);

    for (int i = 0; i < 6; i++) begin
      d0 = done_cnt; h0 = done_hi; a0 = abort_cnt; ah0 = abort_hi;
      run_frame(vecs[i].sample, vecs[i].falls, rx);
      cs = 1'b1;
      wait_clks(2);
      check($sformatf("v%0d_busy_hold", i), 32'(busy), 32'd1);
      wait_clks(1);
      check($sformatf("v%0d_busy_fall", i), 32'(busy), 32'd0);
      wait_clks(HALF);
`ifdef RAMP_GEN_EN
      check($sformatf("v%0d_rx", i), 32'(rx), 32'(exp_word(vecs[i].sample, vecs[i].falls)));
      if (vecs[i].falls == 16) ramp_model = ramp_model + 12'h001;
`else
      check($sformatf("v%0d_rx", i), 32'(rx), 32'(vecs[i].exp_rx));
`endif
      check($sformatf("v%0d_done", i), 32'(done_cnt - d0), 32'(vecs[i].exp_done));
      check($sformatf("v%0d_done_width", i), 32'(done_hi - h0), 32'(vecs[i].exp_done));
      check($sformatf("v%0d_abort", i), 32'(abort_cnt - a0), 32'(vecs[i].exp_abort));
      check($sformatf("v%0d_abort_width", i), 32'(abort_hi - ah0), 32'(vecs[i].exp_abort));
      check($sformatf("v%0d_s_data_idle", i), 32'(s_data), 32'd0);
    end

    // Asynchronous reset mid-frame, then cs held low must not start a frame
    run_frame(12'hFFF, 9, rx);
`ifdef RAMP_GEN_EN
    check("midreset_bit", 32'(s_data), 32'(ramp_model[6]));
`else
    check("midreset_bit", 32'(s_data), 32'd1);
`endif
    #20 rst_n = 1'b0;
    #1;
    check("midreset_s_data", 32'(s_data), 32'd0);
    check("midreset_busy", 32'(busy), 32'd0);
    ramp_model = 12'h000;
    wait_clks(3);
    rst_n = 1'b1;
    wait_clks(10);
    busy_seen = 1'b0; sd_seen = 1'b0;
    for (int i = 0; i < 4; i++) begin
      s_clk = 1'b0; wait_clks(HALF); busy_seen |= busy; sd_seen |= s_data;
      s_clk = 1'b1; wait_clks(HALF); busy_seen |= busy; sd_seen |= s_data;
    end
    check("cs_low_after_reset_busy", 32'(busy_seen), 32'd0);
    check("cs_low_after_reset_s_data", 32'(sd_seen), 32'd0);
    cs = 1'b1;
    wait_clks(HALF);
    d0 = done_cnt;
    run_frame(12'h3C7, 16, rx);
    cs = 1'b1;
    wait_clks(HALF);
    check("post_reset_rx", 32'(rx), 32'(exp_word(12'h3C7, 16)));
    check("post_reset_done", 32'(done_cnt - d0), 32'd1);
    ramp_model = ramp_model + 12'h001;

    // Extra s_clk pulses after the last bit and toggling with cs high
    d0 = done_cnt; a0 = abort_cnt;
    run_frame(12'h7E1, 16, rx);
    check("overrun_rx", 32'(rx), 32'(exp_word(12'h7E1, 16)));
    ramp_model = ramp_model + 12'h001;
    sd_seen = 1'b0; busy_seen = 1'b0;
    for (int i = 0; i < 4; i++) begin
      s_clk = 1'b0; wait_clks(HALF); sd_seen |= s_data;
      s_clk = 1'b1; wait_clks(HALF); sd_seen |= s_data;
    end
    cs = 1'b1;
    wait_clks(HALF);
    for (int i = 0; i < 6; i++) begin
      s_clk = 1'b0; wait_clks(HALF); sd_seen |= s_data; busy_seen |= busy;
      s_clk = 1'b1; wait_clks(HALF); sd_seen |= s_data; busy_seen |= busy;
    end
    check("overrun_s_data", 32'(sd_seen), 32'd0);
    check("cs_high_busy", 32'(busy_seen), 32'd0);
    check("overrun_done", 32'(done_cnt - d0), 32'd1);
    check("overrun_abort", 32'(abort_cnt - a0), 32'd0);

    // cs rise coincident with the final falling edge: done, no abort, back to IDLE
    d0 = done_cnt; a0 = abort_cnt;
    run_frame(12'h9B4, 15, rx);
    rx = {rx[14:0], s_data};
    cs = 1'b1;
    s_clk = 1'b0;
    wait_clks(HALF);
    s_clk = 1'b1;
    wait_clks(HALF);
    check("coincide_rx", 32'(rx), 32'(exp_word(12'h9B4, 16)));
    check("coincide_done", 32'(done_cnt - d0), 32'd1);
    check("coincide_abort", 32'(abort_cnt - a0), 32'd0);
    check("coincide_busy", 32'(busy), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
